// File: rtl/e203_sysmem_icb_sram_if.sv
// ICB command/response bundle for the system-memory SRAM port.
interface e203_sysmem_icb_sram_if #(
  parameter int AW = 32
);
  logic          icb_cmd_valid;
  logic          icb_cmd_ready;
  logic [AW-1:0] icb_cmd_addr;
  logic          icb_cmd_read;
  logic [31:0]   icb_cmd_wdata;
  logic [3:0]    icb_cmd_wmask;
  logic          icb_rsp_valid;
  logic          icb_rsp_ready;
  logic          icb_rsp_err;
  logic [31:0]   icb_rsp_rdata;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );
  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );
endinterface

// File: rtl/e203_sysmem_icb_sram.sv
// ICB slave onto a 1-cycle-latency 32-bit SRAM with a small in-order response FIFO.
// Optional: E203_SYSMEM_MISALIGN_ERR_EN turns non-word-aligned addresses into error responses.
module e203_sysmem_icb_sram #(
  parameter int          AW        = 32,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          RAM_AW    = 14,
  parameter int          RSP_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  e203_sysmem_icb_sram_if.slave icb,
  output logic                sram_cs,
  output logic                sram_we,
  output logic [3:0]          sram_wem,
  output logic [RAM_AW-1:0]   sram_addr,
  output logic [31:0]         sram_din,
  input  logic [31:0]         sram_dout,
  output logic                busy
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);

  logic          hs, pop, in_win;
  logic          s1_valid, s1_read, s1_err;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   occ;
  logic [PW-1:0] wptr, rptr;
  logic          err_q   [RSP_DEPTH];
  logic [31:0]   rdata_q [RSP_DEPTH];
  logic          unused_addr_lo;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign hs  = icb.icb_cmd_valid & icb.icb_cmd_ready;
  assign pop = icb.icb_rsp_valid & icb.icb_rsp_ready;

  // Entries in flight (s1) reserve a FIFO slot, so a push can never overflow.
  assign occ = {1'b0, fifo_cnt} + (CW+1)'(s1_valid) - (CW+1)'(pop);
  assign icb.icb_cmd_ready = (occ < (CW+1)'(RSP_DEPTH));

`ifdef E203_SYSMEM_MISALIGN_ERR_EN
  assign in_win = (icb.icb_cmd_addr[AW-1:RAM_AW+2] == BASE[AW-1:RAM_AW+2])
                & (icb.icb_cmd_addr[1:0] == 2'b00);
  assign unused_addr_lo = 1'b0;
`else
  assign in_win = (icb.icb_cmd_addr[AW-1:RAM_AW+2] == BASE[AW-1:RAM_AW+2]);
  assign unused_addr_lo = ^icb.icb_cmd_addr[1:0];
`endif

  assign sram_cs   = hs & in_win;
  assign sram_we   = ~icb.icb_cmd_read;
  assign sram_wem  = icb.icb_cmd_read ? 4'b0 : icb.icb_cmd_wmask;
  assign sram_addr = icb.icb_cmd_addr[RAM_AW+1:2];
  assign sram_din  = icb.icb_cmd_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_read  <= 1'b0;
      s1_err   <= 1'b0;
      fifo_cnt <= '0;
      wptr     <= '0;
      rptr     <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        err_q[i]   <= 1'b0;
        rdata_q[i] <= 32'h0;
      end
    end else begin
      s1_valid <= hs;
      if (hs) begin
        s1_read <= icb.icb_cmd_read;
        s1_err  <= ~in_win;
      end
      // SRAM data is valid exactly in the s1 cycle, so it is captured here.
      if (s1_valid) begin
        err_q[wptr]   <= s1_err;
        rdata_q[wptr] <= (s1_read & ~s1_err) ? sram_dout : 32'h0;
        wptr          <= nxt(wptr);
      end
      if (pop) rptr <= nxt(rptr);
      case ({s1_valid, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign icb.icb_rsp_valid = (fifo_cnt != '0);
  assign icb.icb_rsp_err   = icb.icb_rsp_valid ? err_q[rptr]   : 1'b0;
  assign icb.icb_rsp_rdata = icb.icb_rsp_valid ? rdata_q[rptr] : 32'h0;
  assign busy = s1_valid | (fifo_cnt != '0);
endmodule

// File: tb/tb_e203_sysmem_icb_sram.sv
// Directed scoreboard bench for e203_sysmem_icb_sram with a behavioural SRAM.
module tb_e203_sysmem_icb_sram;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sram_cs, sram_we, busy;
  logic [3:0]  sram_wem;
  logic [13:0] sram_addr;
  logic [31:0] sram_din, sram_dout;
  logic [31:0] mem [16384];

  typedef struct { logic err; logic [31:0] rdata; } rsp_t;
  rsp_t q[$];
  int checks = 0;
  int failures = 0;

  e203_sysmem_icb_sram_if #(.AW(32)) icb ();

  e203_sysmem_icb_sram dut (
    .clk(clk), .rst_n(rst_n), .icb(icb),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_wem(sram_wem),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wem[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response checker: pops the scoreboard on each response handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && icb.icb_rsp_valid === 1'b1 && icb.icb_rsp_ready === 1'b1) begin
      if (q.size() == 0) chk("unexpected_rsp", 32'h1, 32'h0);
      else begin
        rsp_t e;
        e = q.pop_front();
        chk("rsp_err", {31'h0, icb.icb_rsp_err}, {31'h0, e.err});
        chk("rsp_rdata", icb.icb_rsp_rdata, e.rdata);
      end
    end
  end

  // Drives one command starting just after a posedge; returns just after its handshake edge.
  task automatic cmd(input logic [31:0] a, input logic rd, input logic [31:0] wd, input logic [3:0] wm,
                     input logic e_err, input logic [31:0] e_rd, input logic e_cs, output int stalls);
    rsp_t e;
    stalls = 0;
    icb.icb_cmd_valid = 1'b1; icb.icb_cmd_addr = a; icb.icb_cmd_read = rd;
    icb.icb_cmd_wdata = wd;   icb.icb_cmd_wmask = wm;
    @(negedge clk);
    while (!icb.icb_cmd_ready && stalls < 50) begin @(negedge clk); stalls++; end
    if (!icb.icb_cmd_ready) chk("cmd_timeout", 32'h0, 32'h1);
    else begin
      e.err = e_err; e.rdata = e_rd;
      q.push_back(e);
      chk("sram_cs", {31'h0, sram_cs}, {31'h0, e_cs});
      if (e_cs) chk("sram_addr", {18'h0, sram_addr}, {18'h0, a[15:2]});
    end
    @(posedge clk); #1;
    icb.icb_cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int st, hs_cnt, tot;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    sram_dout = 32'h0;
    icb.icb_cmd_valid = 1'b1; icb.icb_cmd_addr = 32'h8000_0000; icb.icb_cmd_read = 1'b1;
    icb.icb_cmd_wdata = 32'h0; icb.icb_cmd_wmask = 4'h0; icb.icb_rsp_ready = 1'b1;
    rst_n = 1'b0;

    // 1. reset and first-response latency
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'h0, icb.icb_rsp_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rsp_rdata", icb.icb_rsp_rdata, 32'h0);
    icb.icb_cmd_valid = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    cmd(32'h8000_0000, 1'b1, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, st);
    @(negedge clk);
    chk("lat_n1_valid", {31'h0, icb.icb_rsp_valid}, 32'h0);
    chk("lat_n1_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("lat_n2_valid", {31'h0, icb.icb_rsp_valid}, 32'h1);
    @(posedge clk); #1;
    drain();

    // 2. write then read
    cmd(32'h8000_0010, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 1'b1, st);
    cmd(32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, st);
    drain();

    // 3. byte mask
    cmd(32'h8000_0020, 1'b0, 32'h1122_3344, 4'hF, 1'b0, 32'h0, 1'b1, st);
    cmd(32'h8000_0020, 1'b0, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0, 1'b1, st);
    cmd(32'h8000_0020, 1'b1, 32'h0, 4'h0, 1'b0, 32'h11BB_33DD, 1'b1, st);
    drain();

    // 4. out of window, then in-window read
    cmd(32'h9000_0000, 1'b1, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, st);
    cmd(32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, st);
    drain();

    // 5. backpressure: only RSP_DEPTH commands accepted while rsp_ready is low
    icb.icb_rsp_ready = 1'b0;
    icb.icb_cmd_valid = 1'b1; icb.icb_cmd_addr = 32'h8000_0010; icb.icb_cmd_read = 1'b1;
    hs_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (icb.icb_cmd_ready) begin
        rsp_t e;
        e.err = 1'b0; e.rdata = 32'hDEAD_BEEF;
        q.push_back(e);
        hs_cnt++;
      end
    end
    chk("bp_hs_count", hs_cnt, 2);
    chk("bp_ready_full", {31'h0, icb.icb_cmd_ready}, 32'h0);
    chk("bp_busy", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    icb.icb_cmd_valid = 1'b0; icb.icb_rsp_ready = 1'b1;
    #1;
    chk("bp_ready_comb", {31'h0, icb.icb_cmd_ready}, 32'h1);
    @(posedge clk); #1;
    drain();
    tot = 0;
    cmd(32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, st); tot += st;
    cmd(32'h8000_0020, 1'b1, 32'h0, 4'h0, 1'b0, 32'h11BB_33DD, 1'b1, st); tot += st;
    cmd(32'h8000_0030, 1'b0, 32'h5566_7788, 4'hF, 1'b0, 32'h0, 1'b1, st); tot += st;
    cmd(32'h8000_0030, 1'b1, 32'h0, 4'h0, 1'b0, 32'h5566_7788, 1'b1, st); tot += st;
    chk("thru_stalls", tot, 0);
    drain();

    // 6. misaligned access
    cmd(32'h8000_0000, 1'b0, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 1'b1, st);
`ifdef E203_SYSMEM_MISALIGN_ERR_EN
    cmd(32'h8000_0002, 1'b1, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, st);
`else
    cmd(32'h8000_0002, 1'b1, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D, 1'b1, st);
`endif
    drain();

    // 7. reset mid-operation discards buffered responses
    icb.icb_rsp_ready = 1'b0;
    cmd(32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, st);
    cmd(32'h8000_0020, 1'b1, 32'h0, 4'h0, 1'b0, 32'h11BB_33DD, 1'b1, st);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    icb.icb_rsp_ready = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", {31'h0, icb.icb_rsp_valid}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    chk("midrst_quiet", {31'h0, icb.icb_rsp_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
